// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that assembles four LSB-first bytes into one 32-bit word.
// Partial words are dropped on a framing error or when the inter-byte gap exceeds TIMEOUT_BITS.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        rx_valid,
  output logic        frame_err
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          r_state,    w_state;
  logic            r_sync1,    r_sync2;
  logic [CW-1:0]   r_clk_cnt,  w_clk_cnt;
  logic [2:0]      r_bit_idx,  w_bit_idx;
  logic [1:0]      r_byte_idx, w_byte_idx;
  logic [TW-1:0]   r_timeout,  w_timeout;
  logic [7:0]      r_byte,     w_byte;
  logic [23:0]     r_word,     w_word;
  logic [31:0]     w_data_out;
  logic            w_rx_valid, w_frame_err;
  logic            w_rx_s;

  assign w_rx_s = r_sync2;

  // NOTE: sequential state uses non-blocking assignments only; the synchroniser
  // resets to 1 so a reset never looks like a falling start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_timeout  <= '0;
      r_byte     <= '0;
      r_word     <= '0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_sync1    <= data_in;
      r_sync2    <= r_sync1;
      r_state    <= w_state;
      r_clk_cnt  <= w_clk_cnt;
      r_bit_idx  <= w_bit_idx;
      r_byte_idx <= w_byte_idx;
      r_timeout  <= w_timeout;
      r_byte     <= w_byte;
      r_word     <= w_word;
      data_out   <= w_data_out;
      rx_valid   <= w_rx_valid;
      frame_err  <= w_frame_err;
    end
  end

  // NOTE: every next-value signal is defaulted first so no latch is inferred.
  always_comb begin
    w_state     = r_state;
    w_clk_cnt   = r_clk_cnt;
    w_bit_idx   = r_bit_idx;
    w_byte_idx  = r_byte_idx;
    w_timeout   = r_timeout;
    w_byte      = r_byte;
    w_word      = r_word;
    w_data_out  = data_out;
    w_rx_valid  = 1'b0;
    w_frame_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_cnt = '0;
        // A start edge takes priority over an expiring timeout.
        if (!w_rx_s) begin
          w_state = S_START;
        end else if (r_byte_idx != 2'd0) begin
          if (r_timeout == TO_LAST) begin
            w_byte_idx = '0;
            w_word     = '0;
            w_timeout  = '0;
          end else begin
            w_timeout = r_timeout + 1'b1;
          end
        end
      end

      S_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt = '0;
          if (!w_rx_s) begin
            w_state   = S_DATA;
            w_bit_idx = '0;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_clk_cnt = r_clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt         = '0;
          w_byte[r_bit_idx] = w_rx_s;
          if (r_bit_idx == 3'd7) w_state = S_STOP;
          else                   w_bit_idx = r_bit_idx + 1'b1;
        end else begin
          w_clk_cnt = r_clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt = '0;
          if (w_rx_s) begin
            w_state = S_IDLE;
            if (r_byte_idx == 2'd3) begin
              w_data_out = {r_byte, r_word};
              w_rx_valid = 1'b1;
              w_byte_idx = '0;
              w_word     = '0;
            end else begin
              w_word[{r_byte_idx, 3'b000} +: 8] = r_byte;
              w_byte_idx = r_byte_idx + 1'b1;
              w_timeout  = '0;
            end
          end else begin
            w_state     = S_BREAK;
            w_frame_err = 1'b1;
            w_byte_idx  = '0;
            w_word      = '0;
          end
        end else begin
          w_clk_cnt = r_clk_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        if (w_rx_s) w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: expected words are queued as frames are driven
// and popped by a monitor whenever rx_valid pulses.
`timescale 1ns/1ps
module tb_uart_rx_word;

  localparam int  CPB    = 16;
  localparam int  TOB    = 20;
  localparam real BIT_NS = 160.0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in = 1'b1;
  logic [31:0] data_out;
  logic        rx_valid;
  logic        frame_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          n_valid = 0;
  int          n_ferr  = 0;
  longint      cyc = 0;
  longint      t_last = 0;
  longint      t_prev = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ferr  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
    end else begin
      if (rx_valid || frame_err) begin
        checks++;
        if (rx_valid && frame_err) begin
          errors++;
          $display("FAIL pulse_overlap: rx_valid=1 frame_err=1, required never both");
        end
      end
      if (rx_valid) begin
        n_valid++;
        t_prev = t_last;
        t_last = cyc;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL rx_valid_width: high for 2+ cycles, required 1");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no rx_valid", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (data_out !== mon_exp) begin
            errors++;
            $display("FAIL data_out: got %h, required %h", data_out, mon_exp);
          end
        end
      end
      if (frame_err) begin
        n_ferr++;
        checks++;
        if (prev_ferr) begin
          errors++;
          $display("FAIL frame_err_width: high for 2+ cycles, required 1");
        end
      end
      prev_valid = rx_valid;
      prev_ferr  = frame_err;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input real bit_ns);
    data_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      #(bit_ns);
    end
    data_in = stop;
    #(bit_ns);
  endtask

  task automatic send_word(input logic [31:0] w, input real bit_ns);
    exp_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], 1'b1, bit_ns);
  endtask

  task automatic idle_bits(input real n);
    data_in = 1'b1;
    #(n * BIT_NS);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL %s_data_out: got %h, required 00000000", name, data_out);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_rx_valid: got %b, required 0", name, rx_valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_frame_err: got %b, required 0", name, frame_err);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
  endtask

  task automatic test_single_word();
    int v0 = n_valid;
    int f0 = n_ferr;
    send_word(32'h12345678, BIT_NS);
    idle_bits(2);
    wait_drain("single");
    check_count("single_valid_count", n_valid, v0 + 1);
    check_count("single_ferr_count", n_ferr, f0);
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    send_word(32'hDEADBEEF, BIT_NS);
    send_word(32'h00000001, BIT_NS);
    idle_bits(2);
    wait_drain("b2b");
    check_count("b2b_valid_count", n_valid, v0 + 2);
    check_count("b2b_spacing_cycles", int'(t_last - t_prev), 40 * CPB);
  endtask

  task automatic test_glitch();
    int v0 = n_valid;
    int f0 = n_ferr;
    @(negedge clk);
    data_in = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    data_in = 1'b1;
    idle_bits(3);
    check_count("glitch_valid_count", n_valid, v0);
    check_count("glitch_ferr_count", n_ferr, f0);
    send_word(32'h89ABCDEF, BIT_NS);
    idle_bits(2);
    wait_drain("glitch");
    check_count("glitch_ferr_after", n_ferr, f0);
  endtask

  task automatic test_frame_err();
    int v0 = n_valid;
    int f0 = n_ferr;
    send_byte(8'h01, 1'b1, BIT_NS);
    send_byte(8'h02, 1'b1, BIT_NS);
    send_byte(8'h03, 1'b0, BIT_NS);
    #(25 * BIT_NS);
    check_count("ferr_count_break", n_ferr, f0 + 1);
    check_count("ferr_valid_count", n_valid, v0);
    idle_bits(2);
    send_word(32'hA5A5A5A5, BIT_NS);
    idle_bits(2);
    wait_drain("ferr");
    check_count("ferr_count_after", n_ferr, f0 + 1);
    check_count("ferr_valid_after", n_valid, v0 + 1);
  endtask

  task automatic test_timeout();
    int v0 = n_valid;
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    idle_bits(TOB + 1);
    send_word(32'hCAFEF00D, BIT_NS);
    idle_bits(2);
    wait_drain("timeout");
    check_count("timeout_valid_count", n_valid, v0 + 1);
  endtask

  task automatic test_reset_mid();
    int          f0 = n_ferr;
    logic [7:0]  b1 = 8'h66;
    send_byte(8'h55, 1'b1, BIT_NS);
    data_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      data_in = b1[i];
      #(BIT_NS);
    end
    data_in = b1[4];
    #(BIT_NS / 2.0);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    #(4 * BIT_NS);
    data_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    send_word(32'h0BADC0DE, BIT_NS);
    idle_bits(2);
    wait_drain("rst_mid");
    check_count("rst_mid_ferr_count", n_ferr, f0);
  endtask

  task automatic test_tolerance();
    int f0 = n_ferr;
    send_word(32'h5A5AC3C3, BIT_NS * 1.02);
    send_word(32'h3C3CA5A5, BIT_NS * 0.98);
    idle_bits(2);
    wait_drain("tolerance");
    check_count("tolerance_ferr_count", n_ferr, f0);
  endtask

  task automatic test_random_words();
    int v0 = n_valid;
    for (int k = 0; k < 4; k++) send_word($urandom, BIT_NS);
    idle_bits(2);
    wait_drain("random");
    check_count("random_valid_count", n_valid, v0 + 4);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_tolerance();
    test_random_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Serial receive stage that pairs with the design's 32-bit UART transmitter and feeds the AES datapath. It deserialises 8N1 frames from the RS-232 line, idle-high and LSB first, and assembles four consecutive bytes into one 32-bit word. Byte 0 fills bits [7:0] and byte 3 fills bits [31:24], matching the transmitter's word order. When a word is complete, the block presents it with a single-cycle valid pulse.

## Interface
- CLKS_PER_BIT, default 2604: clock cycles per bit (50 MHz / 19200 baud); must be ≥ 8.
- TIMEOUT_BITS, default 20: maximum idle gap between bytes of one word, in bit-times, before a partial word is discarded.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  1  serial RX line; asynchronous to clk; idle = 1.
- data_out  output  32  last completed word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse; data_out is new in that cycle.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.

## Operation
- data_in passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s only.
- Bit counter: 0..CLKS_PER_BIT-1. Bit index: 0..7. Byte index: 0..3. Timeout counter: wide enough for TIMEOUT_BITS*CLKS_PER_BIT.
- The word is built in a 32-bit shift/assembly register. data_out updates only when a full word is accepted.
- States:
  - IDLE: wait for rx_s = 0, then go to START and clear the bit counter. While byte index ≠ 0, the timeout counter runs. On expiry, clear byte index and discard the partial word. Stay in IDLE.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then resample rx_s.
    - rx_s = 0: valid start bit; go to DATA, clear bit index.
    - rx_s = 1: glitch; go to IDLE. No error is flagged and byte index is unchanged.
  - DATA: each CLKS_PER_BIT cycles, sample rx_s into bit [bit index] of the current byte. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s = 1: write the byte to lane [byte index*8 +: 8].
      - Byte index < 3: increment it, clear the timeout counter, go to IDLE.
      - Byte index = 3: load data_out with the full word, pulse rx_valid, clear byte index, go to IDLE.
    - rx_s = 0: pulse frame_err, clear byte index, discard the partial word, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line from being read as a start bit.
- No back-pressure. The consumer must take data_out within one word time (≥ 40 bit-times). data_out stays stable until the next rx_valid.

## Timing
- Reset values (async assert, sync-released by the existing reset tree):
  - data_out = 0, rx_valid = 0, frame_err = 0.
  - State = IDLE; all counters = 0; synchroniser flops = 1.
- Sample point: mid-bit. Start bit is confirmed CLKS_PER_BIT/2 cycles after the falling edge is seen on rx_s. Bit n is sampled (n+1)*CLKS_PER_BIT cycles after start confirmation.
- Latency, line edge to rx_s: 2 clocks.
- Latency, stop-bit mid-sample of byte 3 to rx_valid: 1 clock. data_out is valid in the same cycle as rx_valid.
- rx_valid and frame_err are each exactly one cycle wide and never asserted together.
- Back-to-back frames (stop bit directly followed by the next start bit) must be received without loss.
- Tolerance: ±2% baud mismatch between transmitter and receiver must be received correctly.
- Reset asserted mid-frame: immediate return to the reset state. The partial word is lost and no pulse is emitted.
- Timeout and a start-bit edge in the same cycle: start detection wins, and the partial word is kept.

## Test plan
- Single word, CLKS_PER_BIT = 16, send bytes 0x78, 0x56, 0x34, 0x12 -> one rx_valid pulse with data_out = 0x12345678; frame_err never asserts.
- Two words sent back-to-back with zero gap, 0xDEADBEEF then 0x00000001 -> two rx_valid pulses, each with the correct data_out; the second pulse comes 40 bit-times after the first.
- Low glitch on the idle line lasting CLKS_PER_BIT/4 cycles -> no state change beyond START; no rx_valid or frame_err; the next word is received intact.
- Stop bit of byte 2 forced to 0 -> one frame_err pulse. The block stays in BREAK until the line returns high. A following full word 0xA5A5A5A5 is received correctly.
- Send 2 bytes, then idle for TIMEOUT_BITS+1 bit-times, then send a full word 0xCAFEF00D -> exactly one rx_valid with 0xCAFEF00D.
- Assert rst during bit 4 of byte 1 -> outputs return to 0 immediately. After release, a full word 0x0BADC0DE is received correctly.
- Loopback with the design's transmitter at the default parameters, 4 random words -> all received in order.
